// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter that sequences one APB transfer
// at a time (SETUP/ACCESS) for NUM_REQ requesters, with optional timeout.
//
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   REQ_VALID[NUM_REQ]  request pending, held until its REQ_DONE
//   REQ_ADDR/REQ_WDATA  per-requester address / write data, packed
//                       requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_WRITE[NUM_REQ]  1=write, 0=read
//   REQ_DONE[NUM_REQ]   one-hot single-cycle completion pulse
//   REQ_RDATA, REQ_ERR  read data / error, valid with REQ_DONE
//   PADDR..PWDATA       APB master outputs (to bus decoder slave port)
//   PREADY, PRDATA,     APB slave responses
//   PSLVERR
module apb_master_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ-1:0]            REQ_WRITE,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]            REQ_DONE,
    output logic [DATA_WIDTH-1:0]         REQ_RDATA,
    output logic                          REQ_ERR,
    output logic [DATA_WIDTH-1:0]         PADDR,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic                          PREADY,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PSLVERR
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  cand;
    logic                found;
    logic [IW-1:0]       pick;
    logic [NUM_REQ-1:0]  done_vec;
    logic                timed_out;

    // The requester being acknowledged still holds REQ_VALID during its
    // done cycle, so it is excluded from the candidate set.
    always_comb begin
        cand  = REQ_VALID & ~REQ_DONE;
        found = 1'b0;
        pick  = ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && cand[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    // ptr holds the granted index for the whole transfer.
    always_comb begin
        done_vec      = '0;
        done_vec[ptr] = 1'b1;
    end

    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            cnt       <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            REQ_DONE  <= '0;
            REQ_RDATA <= '0;
            REQ_ERR   <= 1'b0;
        end else begin
            REQ_DONE  <= '0;
            REQ_RDATA <= '0;
            REQ_ERR   <= 1'b0;
            unique case (state)
                IDLE: begin
                    PENABLE <= 1'b0;
                    if (found) begin
                        PADDR  <= REQ_ADDR[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        PWDATA <= REQ_WDATA[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                        PWRITE <= REQ_WRITE[pick];
                        PSEL   <= 1'b1;
                        ptr    <= pick;
                        state  <= SETUP;
                    end else begin
                        PSEL <= 1'b0;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout reached in the same cycle.
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        REQ_DONE  <= done_vec;
                        REQ_ERR   <= PSLVERR;
                        REQ_RDATA <= PWRITE ? '0 : PRDATA;
                        state     <= IDLE;
                    end else if (timed_out) begin
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        REQ_DONE <= done_vec;
                        REQ_ERR  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin / APB slave model.
module tb_apb_master_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 16;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_write;
    logic [NR*DW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]  req_done;
    logic [DW-1:0]  req_rdata;
    logic           req_err;
    logic [DW-1:0]  paddr;
    logic           psel;
    logic           penable;
    logic           pwrite;
    logic [DW-1:0]  pwdata;
    logic           pready;
    logic [DW-1:0]  prdata;
    logic           pslverr;

    int errors = 0;
    int checks = 0;

    apb_master_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ(NR),
        .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .REQ_VALID(req_valid),
        .REQ_ADDR(req_addr),
        .REQ_WRITE(req_write),
        .REQ_WDATA(req_wdata),
        .REQ_DONE(req_done),
        .REQ_RDATA(req_rdata),
        .REQ_ERR(req_err),
        .PADDR(paddr),
        .PSEL(psel),
        .PENABLE(penable),
        .PWRITE(pwrite),
        .PWDATA(pwdata),
        .PREADY(pready),
        .PRDATA(prdata),
        .PSLVERR(pslverr)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(negedge PCLK);
    endtask

    task automatic set_req(input int r, input logic [DW-1:0] a,
                           input logic w, input logic [DW-1:0] d);
        req_addr[r*DW +: DW]  = a;
        req_wdata[r*DW +: DW] = d;
        req_write[r] = w;
        req_valid[r] = 1'b1;
    endtask

    task automatic do_reset;
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        tick;
        tick;
        PRESET = 1'b0;
    endtask

    task automatic wait_done(input int lim, output logic [NR-1:0] d,
                             output int acc);
        acc = 0;
        d   = '0;
        for (int i = 0; i < lim; i++) begin
            tick;
            if (psel && penable) acc++;
            if (req_done != '0) begin
                d = req_done;
                return;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({psel, penable, pwrite, req_err, req_done} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {psel, penable, pwrite, req_err, req_done});
        end
        checks++;
        if ((paddr | pwdata | req_rdata) !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h want 0",
                     paddr, pwdata, req_rdata);
        end
        tick;
        tick;
        checks++;
        if (psel !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_psel: got %b want 0", psel);
        end
    endtask

    task automatic test_single_write;
        set_req(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        pready = 1'b1;
        tick;
        checks++;
        if ({psel, penable, pwrite} !== 3'b101) begin
            errors++;
            $display("FAIL wr_setup_ctrl: got %b want 101",
                     {psel, penable, pwrite});
        end
        checks++;
        if (paddr !== 32'h10 || pwdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_setup_data: got %h/%h want 10/deadbeef",
                     paddr, pwdata);
        end
        tick;
        checks++;
        if ({psel, penable} !== 2'b11 || req_done !== 2'b00) begin
            errors++;
            $display("FAIL wr_access: got %b/%b want 11/00",
                     {psel, penable}, req_done);
        end
        tick;
        checks++;
        if (req_done !== 2'b01 || req_err !== 1'b0 || req_rdata !== '0) begin
            errors++;
            $display("FAIL wr_done: got %b/%b/%h want 01/0/0",
                     req_done, req_err, req_rdata);
        end
        tick;
        req_valid[0] = 1'b0;
        checks++;
        if (req_done !== 2'b00 || psel !== 1'b0) begin
            errors++;
            $display("FAIL wr_after: got %b/%b want 00/0", req_done, psel);
        end
        tick;
    endtask

    task automatic test_round_robin;
        int nset = 0;
        int nd = 0;
        logic [NR-1:0] dropnext = '0;
        logic [DW-1:0] ea;
        logic [NR-1:0] ed;
        do_reset;
        pready = 1'b1;
        prdata = 32'h0BAD_CAFE;
        set_req(0, 32'h100, 1'b0, '0);
        set_req(1, 32'h200, 1'b0, '0);
        for (int i = 0; i < 60 && nd < 4; i++) begin
            tick;
            req_valid = req_valid & ~dropnext;
            dropnext = '0;
            if (psel && !penable) begin
                ea = (nset % 2 == 0) ? 32'h100 : 32'h200;
                checks++;
                if (paddr !== ea) begin
                    errors++;
                    $display("FAIL rr_paddr%0d: got %h want %h", nset, paddr, ea);
                end
                nset++;
            end
            if (req_done != '0) begin
                ed = (nd % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (req_done !== ed || req_rdata !== 32'h0BAD_CAFE) begin
                    errors++;
                    $display("FAIL rr_done%0d: got %b/%h want %b/0badcafe",
                             nd, req_done, req_rdata, ed);
                end
                if (nd >= 2) dropnext = req_done;
                nd++;
            end
        end
        tick;
        req_valid = req_valid & ~dropnext;
        checks++;
        if (nd !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d want 4", nd);
        end
        tick;
        tick;
        checks++;
        if (psel !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got %b want 0", psel);
        end
    endtask

    task automatic test_wait_states;
        int acc = 0;
        logic [NR-1:0] d = '0;
        pready = 1'b0;
        prdata = 32'h1234_5678;
        set_req(1, 32'h0000_1004, 1'b0, '0);
        for (int i = 0; i < 30; i++) begin
            tick;
            if (psel && penable) begin
                acc++;
                checks++;
                if (paddr !== 32'h1004) begin
                    errors++;
                    $display("FAIL ws_addr_stable: got %h want 1004", paddr);
                end
                if (acc == 4) pready = 1'b1;
            end
            if (req_done != '0) begin
                d = req_done;
                break;
            end
        end
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL ws_penable_cycles: got %0d want 4", acc);
        end
        checks++;
        if (d !== 2'b10 || req_rdata !== 32'h1234_5678 || req_err !== 1'b0) begin
            errors++;
            $display("FAIL ws_done: got %b/%h/%b want 10/12345678/0",
                     d, req_rdata, req_err);
        end
        tick;
        req_valid[1] = 1'b0;
        tick;
    endtask

    task automatic test_slverr;
        int acc;
        logic [NR-1:0] d;
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hBAD0_0000;
        set_req(0, 32'h0000_5000, 1'b0, '0);
        wait_done(10, d, acc);
        checks++;
        if (d !== 2'b01 || req_err !== 1'b1 || req_rdata !== 32'hBAD0_0000) begin
            errors++;
            $display("FAIL err_done: got %b/%b/%h want 01/1/bad00000",
                     d, req_err, req_rdata);
        end
        tick;
        pslverr = 1'b0;
        prdata  = 32'h0000_55AA;
        set_req(0, 32'h0000_0020, 1'b0, '0);
        wait_done(10, d, acc);
        checks++;
        if (d !== 2'b01 || req_err !== 1'b0 || req_rdata !== 32'h55AA) begin
            errors++;
            $display("FAIL err_clean: got %b/%b/%h want 01/0/55aa",
                     d, req_err, req_rdata);
        end
        tick;
        req_valid[0] = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        int acc;
        logic [NR-1:0] d;
        pready = 1'b0;
        prdata = 32'hFFFF_0000;
        set_req(0, 32'h30, 1'b0, '0);
        wait_done(40, d, acc);
        checks++;
        if (acc !== TO) begin
            errors++;
            $display("FAIL to_cycles: got %0d want %0d", acc, TO);
        end
        checks++;
        if (d !== 2'b01 || req_err !== 1'b1 || req_rdata !== '0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL to_abort: got %b/%b/%h/%b want 01/1/0/0",
                     d, req_err, req_rdata, psel);
        end
        tick;
        set_req(0, 32'h34, 1'b0, '0);
        acc = 0;
        d = '0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (psel && penable) begin
                acc++;
                if (acc == TO) begin
                    pready = 1'b1;
                    prdata = 32'hCAFE_F00D;
                end
            end
            if (req_done != '0) begin
                d = req_done;
                break;
            end
        end
        checks++;
        if (acc !== TO || d !== 2'b01 || req_err !== 1'b0 ||
            req_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL to_edge_ready: got %0d/%b/%b/%h want 16/01/0/cafef00d",
                     acc, d, req_err, req_rdata);
        end
        pready = 1'b0;
        tick;
        req_valid[0] = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int acc;
        int nset;
        logic [NR-1:0] d;
        logic [DW-1:0] first_a;
        logic [DW-1:0] ea;
        for (int v = 0; v < 2; v++) begin
            pready = 1'b0;
            set_req(1, 32'h40, 1'b0, '0);
            for (int i = 0; i < 10 && !(psel && penable); i++) tick;
            PRESET = 1'b1;
            tick;
            PRESET = 1'b0;
            checks++;
            if ({psel, penable, pwrite, req_err, req_done} !== '0 ||
                (paddr | pwdata | req_rdata) !== '0) begin
                errors++;
                $display("FAIL rst_mid_outputs%0d: got %b %h %h %h want 0", v,
                         {psel, penable, pwrite, req_err, req_done},
                         paddr, pwdata, req_rdata);
            end
            if (v == 0) set_req(0, 32'h44, 1'b0, '0);
            pready = 1'b1;
            nset = 0;
            d = '0;
            first_a = '0;
            for (int i = 0; i < 20; i++) begin
                tick;
                if (psel && !penable) begin
                    if (nset == 0) first_a = paddr;
                    nset++;
                end
                if (req_done != '0) begin
                    d = req_done;
                    break;
                end
            end
            ea = (v == 0) ? 32'h44 : 32'h40;
            checks++;
            if (nset !== 1 || first_a !== ea) begin
                errors++;
                $display("FAIL rst_mid_grant%0d: got %0d/%h want 1/%h",
                         v, nset, first_a, ea);
            end
            checks++;
            if (d !== ((v == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL rst_mid_done%0d: got %b", v, d);
            end
            tick;
            if (v == 0) begin
                req_valid[0] = 1'b0;
                wait_done(20, d, acc);
                checks++;
                if (d !== 2'b10) begin
                    errors++;
                    $display("FAIL rst_mid_req1: got %b want 10", d);
                end
                tick;
            end
            req_valid[1] = 1'b0;
            tick;
        end
    endtask

    task automatic new_req(input int r);
        set_req(r, $urandom & 32'h0000_FFFC, 1'($urandom_range(1, 0)), $urandom);
    endtask

    task automatic test_random;
        int last = NR - 1;
        int g = 0;
        int eg = 0;
        int waits = 0;
        bit busy = 0;
        bit exp_done = 0;
        bit exp_setup = 0;
        bit fnd;
        logic [DW-1:0] e_rd = '0;
        logic e_err = 1'b0;
        logic [NR-1:0] chg = '0;
        logic [NR-1:0] chg_now;
        logic [NR-1:0] cand;
        logic [NR-1:0] ed;
        do_reset;
        for (int c = 0; c < 1500 && errors < 20; c++) begin
            tick;
            chg_now = chg;
            chg = '0;
            for (int r = 0; r < NR; r++) begin
                if (chg_now[r]) begin
                    if ($urandom_range(1, 0) == 0) req_valid[r] = 1'b0;
                    else new_req(r);
                end else if (!req_valid[r] && $urandom_range(2, 0) == 0) begin
                    new_req(r);
                end
            end
            if (exp_done) begin
                ed = '0;
                ed[g] = 1'b1;
                checks++;
                if (req_done !== ed || req_rdata !== e_rd || req_err !== e_err) begin
                    errors++;
                    $display("FAIL rnd_done: got %b/%h/%b want %b/%h/%b",
                             req_done, req_rdata, req_err, ed, e_rd, e_err);
                end
                exp_done = 0;
                busy = 0;
                chg[g] = 1'b1;
            end else begin
                checks++;
                if (req_done !== '0) begin
                    errors++;
                    $display("FAIL rnd_spurious_done: got %b want 00", req_done);
                end
            end
            pready = 1'($urandom_range(1, 0));
            if (exp_setup) begin
                checks++;
                if ({psel, penable} !== 2'b10 ||
                    paddr !== req_addr[eg*DW +: DW] ||
                    pwdata !== req_wdata[eg*DW +: DW] ||
                    pwrite !== req_write[eg]) begin
                    errors++;
                    $display("FAIL rnd_setup: got %b %h %h %b want 10 %h %h %b (req %0d)",
                             {psel, penable}, paddr, pwdata, pwrite,
                             req_addr[eg*DW +: DW], req_wdata[eg*DW +: DW],
                             req_write[eg], eg);
                end
                g = eg;
                last = eg;
                busy = 1;
                waits = $urandom_range(3, 0);
            end else if (!busy) begin
                checks++;
                if (psel !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle_psel: got %b want 0", psel);
                end
            end else begin
                checks++;
                if ({psel, penable} !== 2'b11 || paddr !== req_addr[g*DW +: DW]) begin
                    errors++;
                    $display("FAIL rnd_access: got %b %h want 11 %h",
                             {psel, penable}, paddr, req_addr[g*DW +: DW]);
                end
                prdata = $urandom;
                if (waits == 0) begin
                    pready   = 1'b1;
                    pslverr  = 1'($urandom_range(1, 0));
                    exp_done = 1;
                    e_rd     = req_write[g] ? '0 : prdata;
                    e_err    = pslverr;
                end else begin
                    pready = 1'b0;
                    waits--;
                end
            end
            cand = busy ? '0 : (req_valid & ~req_done);
            exp_setup = 0;
            fnd = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!fnd && cand[(last + k) % NR]) begin
                    fnd = 1;
                    eg = (last + k) % NR;
                end
            end
            exp_setup = fnd;
        end
    endtask

    initial begin
        do_reset;
        test_reset;
        test_single_write;
        test_round_robin;
        test_wait_states;
        test_slverr;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
